// File: rtl/mem_data_arb_pkg.sv
// mem_data_arb_pkg
// Shared definitions for the two-port data-memory arbiter: the arbiter
// state encoding, the port-index constants (0 = CPU, 1 = DMA/debug) and the
// default width/burst constants used as parameter defaults.
// No ports (package).
package mem_data_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int DEFAULT_ADDR_W    = 10;
  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_MAX_BURST = 8;

endpackage

// File: rtl/mem_data_arb.sv
// mem_data_arb
// Arbitrates a single-port data memory between port 0 (riscv_cpu) and
// port 1 (DMA/debug). At most one access is issued per cycle; an owner may
// keep the memory for up to MAX_BURST consecutive grants while the other
// port waits. Reads return one cycle after the grant, routed back to the
// requesting port by a one-bit registered tag.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   - simultaneous requests seen from IDLE go to the port that did
//               not own the memory last (port 1 first after reset)
//   undefined - simultaneous requests seen from IDLE always go to port 0
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   mN_req/wen/addr/wdata       port N access request (N = 0 CPU, 1 DMA)
//   mN_gnt                      port N access issued this cycle (combinational)
//   mN_rvalid/rdata             port N read data, one cycle after a read grant
//   mem_cen/wen/addr/wdata      memory command bus (all zero when idle)
//   mem_rdata                   memory read data, valid one cycle after a read
module mem_data_arb
  import mem_data_arb_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // bcnt holds (grants so far in this ownership run) - 1 and saturates here
  localparam logic [3:0] BCNT_MAX = 4'(MAX_BURST - 1);

  arb_state_t state, state_nxt;
  logic [3:0] bcnt, bcnt_nxt;
  logic       gnt0_arb, gnt1_arb;
  logic       tie_m1;
  logic       rd_pend;
  logic       rd_port;

`ifdef MEM_ARB_RR_EN
  // Preferred port for an IDLE tie: the port that did not own last.
  // Reset value 1 means the DMA port wins the first tie.
  logic rr_pref;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_pref <= PORT_DMA;
    end else if (m0_gnt) begin
      rr_pref <= PORT_DMA;
    end else if (m1_gnt) begin
      rr_pref <= PORT_CPU;
    end
  end

  assign tie_m1 = rr_pref;
`else
  assign tie_m1 = 1'b0;
`endif

  // Arbitration decision: grant, next state and next burst count
  always_comb begin
    gnt0_arb  = 1'b0;
    gnt1_arb  = 1'b0;
    state_nxt = state;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        bcnt_nxt = 4'd0;
        if (m0_req && m1_req) begin
          if (tie_m1) begin
            gnt1_arb  = 1'b1;
            state_nxt = OWN1;
          end else begin
            gnt0_arb  = 1'b1;
            state_nxt = OWN0;
          end
        end else if (m0_req) begin
          gnt0_arb  = 1'b1;
          state_nxt = OWN0;
        end else if (m1_req) begin
          gnt1_arb  = 1'b1;
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (m0_req && (!m1_req || bcnt < BCNT_MAX)) begin
          gnt0_arb = 1'b1;
          bcnt_nxt = (bcnt == BCNT_MAX) ? bcnt : bcnt + 4'd1;
        end else if (m1_req) begin
          gnt1_arb  = 1'b1;
          state_nxt = OWN1;
          bcnt_nxt  = 4'd0;
        end else begin
          state_nxt = IDLE;
          bcnt_nxt  = 4'd0;
        end
      end
      OWN1: begin
        if (m1_req && (!m0_req || bcnt < BCNT_MAX)) begin
          gnt1_arb = 1'b1;
          bcnt_nxt = (bcnt == BCNT_MAX) ? bcnt : bcnt + 4'd1;
        end else if (m0_req) begin
          gnt0_arb  = 1'b1;
          state_nxt = OWN0;
          bcnt_nxt  = 4'd0;
        end else begin
          state_nxt = IDLE;
          bcnt_nxt  = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        bcnt_nxt  = 4'd0;
      end
    endcase
  end

  // Grants are masked during reset so the reset cycle issues nothing
  assign m0_gnt = gnt0_arb & ~reset;
  assign m1_gnt = gnt1_arb & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // Read tag: remembers that last cycle issued a read and for which port
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_port <= PORT_CPU;
    end else begin
      rd_pend <= (m0_gnt & ~m0_wen) | (m1_gnt & ~m1_wen);
      rd_port <= m1_gnt ? PORT_DMA : PORT_CPU;
    end
  end

  // Returning read data is dropped if reset arrives in the return cycle
  assign m0_rvalid = rd_pend & (rd_port == PORT_CPU) & ~reset;
  assign m1_rvalid = rd_pend & (rd_port == PORT_DMA) & ~reset;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  // Memory command mux; the bus is forced to zero when nothing is granted
  always_comb begin
    mem_cen   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_cen   = 1'b1;
      mem_wen   = m0_wen;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_cen   = 1'b1;
      mem_wen   = m1_wen;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

endmodule

// File: tb/tb_mem_data_arb.sv
// tb_mem_data_arb
// Self-checking bench for mem_data_arb. A behavioural model tracks the
// current owner, the length of its grant run and a shadow copy of memory,
// and predicts grants, the memory bus and read returns each cycle.
// Honours MEM_ARB_RR_EN for the IDLE tie-break expectation.
module tb_mem_data_arb;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_wen, m1_req, m1_wen;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_cen, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              init_phase;

  logic [DATA_W-1:0] mem    [0:DEPTH-1];
  logic [DATA_W-1:0] shadow [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                own;
  int                run;
  bit                pv;
  int                pp;
  logic [DATA_W-1:0] pd;
  bit                rr_pref;

  always #5 clk = ~clk;

  mem_data_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DATA_W-1:0] seed_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // One-cycle-latency memory attached to the DUT command bus
  always @(posedge clk) begin
    if (init_phase) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed_word(i);
    end else begin
      if (mem_cen && mem_wen) mem[mem_addr] <= mem_wdata;
      if (mem_cen && !mem_wen) mem_rdata <= mem[mem_addr];
    end
  end

  // Port the model expects to be granted now (-1 = none)
  function automatic int exp_gnt();
    int o;
    bit ro, rx;
    if (reset) return -1;
    if (own < 0) begin
      if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
        return rr_pref ? 1 : 0;
`else
        return 0;
`endif
      end
      if (m0_req) return 0;
      if (m1_req) return 1;
      return -1;
    end
    o  = own;
    ro = (o == 0) ? m0_req : m1_req;
    rx = (o == 0) ? m1_req : m0_req;
    if (ro && (!rx || run < MAX_BURST)) return o;
    if (rx) return 1 - o;
    return -1;
  endfunction

  // Advance one clock and update the model with what this cycle granted
  task automatic tick();
    int g;
    g = exp_gnt();
    @(posedge clk);
    if (reset) begin
      own = -1; run = 0; pv = 0; rr_pref = 1;
    end else begin
      pv = 0;
      if (g == 0) begin
        pv = !m0_wen; pp = 0; pd = shadow[m0_addr];
        if (m0_wen) shadow[m0_addr] = m0_wdata;
      end else if (g == 1) begin
        pv = !m1_wen; pp = 1; pd = shadow[m1_addr];
        if (m1_wen) shadow[m1_addr] = m1_wdata;
      end
      if (g < 0) begin
        own = -1; run = 0;
      end else if (g == own) begin
        if (run < MAX_BURST) run++;
      end else begin
        own = g; run = 1;
      end
      if (g >= 0) rr_pref = (g == 0);
    end
    #1;
  endtask

  task automatic applyStimulus(input bit r0, input bit w0, input logic [ADDR_W-1:0] a0,
                               input logic [DATA_W-1:0] d0, input bit r1, input bit w1,
                               input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    m0_req = r0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wen = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic drive_idle();
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    init_phase = 1'b1;
    for (int i = 0; i < DEPTH; i++) shadow[i] = seed_word(i);
    applyStimulus(1, 0, 10'h005, 32'h1, 1, 1, 10'h006, 32'h2);
    tick();
    tick();
    #2;
    checks++;
    if ({m0_gnt, m1_gnt, mem_cen, mem_wen, m0_rvalid, m1_rvalid} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 000000",
               {m0_gnt, m1_gnt, mem_cen, mem_wen, m0_rvalid, m1_rvalid});
    end
    checks++;
    if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got addr=%h wdata=%h r0=%h r1=%h want all 0",
               mem_addr, mem_wdata, m0_rdata, m1_rdata);
    end
    init_phase = 1'b0;
    drive_idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    applyStimulus(1, 0, 10'h010, 32'h0, 0, 0, '0, '0);
    #2;
    checks++;
    if ({m0_gnt, m1_gnt, mem_cen, mem_wen, mem_addr} !== {4'b1010, 10'h010}) begin
      errors++;
      $display("[TB] FAIL single_read_issue got g0=%b g1=%b cen=%b wen=%b addr=%h want 1 0 1 0 010",
               m0_gnt, m1_gnt, mem_cen, mem_wen, mem_addr);
    end
    tick();
    drive_idle();
    #2;
    checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("[TB] FAIL single_read_data got v=%b d=%h want 1 deadbeef", m0_rvalid, m0_rdata);
    end
    checks++;
    if ({m1_gnt, m1_rvalid, m1_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL single_read_m1_quiet got g=%b v=%b d=%h want 0", m1_gnt, m1_rvalid, m1_rdata);
    end
    tick();
  endtask

  task automatic test_burst();
    int exp_port;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 10'($urandom), '0, (i != 0), 0, 10'($urandom), '0);
      exp_port = (i < 8 || i >= 16) ? 0 : 1;
      #2;
      checks++;
      if ({m1_gnt, m0_gnt} !== (exp_port == 1 ? 2'b10 : 2'b01)) begin
        errors++;
        $display("[TB] FAIL burst_cycle%0d got g1g0=%b%b want port %0d", i, m1_gnt, m0_gnt, exp_port);
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 10'($urandom), '0, 0, 0, '0, '0);
      tick();
    end
    applyStimulus(1, 0, 10'h001, '0, 1, 0, 10'h002, '0);
    #2;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL saturation_switch got g1g0=%b%b want 10", m1_gnt, m0_gnt);
    end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    applyStimulus(1, 1, 10'h3FF, 32'h55, 0, 0, '0, '0);
    #2;
    checks++;
    if ({m0_gnt, mem_cen, mem_wen, mem_addr, mem_wdata} !== {3'b111, 10'h3FF, 32'h55}) begin
      errors++;
      $display("[TB] FAIL b2b_write got g0=%b cen=%b wen=%b addr=%h wd=%h want 1 1 1 3ff 55",
               m0_gnt, mem_cen, mem_wen, mem_addr, mem_wdata);
    end
    tick();
    applyStimulus(0, 0, '0, '0, 1, 0, 10'h3FF, '0);
    #2;
    checks++;
    if ({m1_gnt, mem_cen, mem_wen, mem_addr, m0_rvalid} !== {3'b110, 10'h3FF, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_read got g1=%b cen=%b wen=%b addr=%h v0=%b want 1 1 0 3ff 0",
               m1_gnt, mem_cen, mem_wen, mem_addr, m0_rvalid);
    end
    tick();
    drive_idle();
    #2;
    checks++;
    if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, 32'h55, 1'b0}) begin
      errors++;
      $display("[TB] FAIL b2b_rdata got v1=%b d1=%h v0=%b want 1 00000055 0", m1_rvalid, m1_rdata, m0_rvalid);
    end
    tick();
  endtask

  task automatic test_tie_after_reset();
    bit [1:0] want;
`ifdef MEM_ARB_RR_EN
    want = 2'b10;
`else
    want = 2'b01;
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1, 0, 10'h020, '0, 1, 0, 10'h021, '0);
    #2;
    checks++;
    if ({m1_gnt, m0_gnt} !== want) begin
      errors++;
      $display("[TB] FAIL tie_after_reset got g1g0=%b%b want %b", m1_gnt, m0_gnt, want);
    end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_reset_after_read();
    int g;
    applyStimulus(0, 0, '0, '0, 1, 0, 10'h0AB, '0);
    #2;
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_read_grant got g1=%b want 1", m1_gnt);
    end
    tick();
    reset = 1'b1;
    #2;
    checks++;
    if ({m0_gnt, m1_gnt, mem_cen, m0_rvalid, m1_rvalid, m1_rdata, mem_addr} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_read_outputs got g=%b%b cen=%b v=%b%b d1=%h addr=%h want 0",
               m0_gnt, m1_gnt, mem_cen, m0_rvalid, m1_rvalid, m1_rdata, mem_addr);
    end
    tick();
    reset = 1'b0;
    applyStimulus(1, 0, 10'h0AC, '0, 1, 0, 10'h0AD, '0);
    #2;
    g = exp_gnt();
    checks++;
    if ({m1_gnt, m0_gnt, m1_rvalid} !== {g == 1, g == 0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL rst_read_idle got g1g0=%b%b v1=%b want port %0d v1 0", m1_gnt, m0_gnt, m1_rvalid, g);
    end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    int g;
    logic [1:0]            exp_g;
    logic [ADDR_W+DATA_W+1:0] exp_bus;
    logic [DATA_W:0]       exp_r0, exp_r1;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      applyStimulus($urandom_range(0, 2) != 0, 1'($urandom), 10'($urandom), $urandom,
                    $urandom_range(0, 2) != 0, 1'($urandom), 10'($urandom), $urandom);
      #2;
      g = exp_gnt();
      exp_g = {g == 1, g == 0};
      if (g == 0)      exp_bus = {1'b1, m0_wen, m0_addr, m0_wdata};
      else if (g == 1) exp_bus = {1'b1, m1_wen, m1_addr, m1_wdata};
      else             exp_bus = '0;
      exp_r0 = (!reset && pv && pp == 0) ? {1'b1, pd} : '0;
      exp_r1 = (!reset && pv && pp == 1) ? {1'b1, pd} : '0;
      checks++;
      if ({m1_gnt, m0_gnt} !== exp_g) begin
        errors++;
        $display("[TB] FAIL rand%0d_gnt got %b%b want %b", c, m1_gnt, m0_gnt, exp_g);
      end
      checks++;
      if ({mem_cen, mem_wen, mem_addr, mem_wdata} !== exp_bus) begin
        errors++;
        $display("[TB] FAIL rand%0d_bus got %h want %h", c, {mem_cen, mem_wen, mem_addr, mem_wdata}, exp_bus);
      end
      checks++;
      if ({m0_rvalid, m0_rdata} !== exp_r0) begin
        errors++;
        $display("[TB] FAIL rand%0d_rd0 got %h want %h", c, {m0_rvalid, m0_rdata}, exp_r0);
      end
      checks++;
      if ({m1_rvalid, m1_rdata} !== exp_r1) begin
        errors++;
        $display("[TB] FAIL rand%0d_rd1 got %h want %h", c, {m1_rvalid, m1_rdata}, exp_r1);
      end
      tick();
    end
    reset = 1'b0;
    drive_idle();
    tick();
  endtask

  initial begin
    own = -1; run = 0; pv = 0; pp = 0; pd = '0; rr_pref = 1;
    reset = 1'b1;
    init_phase = 1'b1;
    drive_idle();
    test_reset();
    test_single_read();
    test_burst();
    test_saturation();
    test_back_to_back();
    test_tie_after_reset();
    test_reset_after_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
